ita_step_sequencer: RTL and testbench
=====================================

Name: ita_step_sequencer

Overview:
- Top-level tile scheduler for the ITA attention datapath. On start it latches the run configuration and walks through the step order below, issuing one tile command per handshake to the datapath.
- Per head, the step order is Q, K, V, QK, AV. After all heads it runs OW.
- It enforces a dependency barrier between steps and bounds the number of in-flight tiles.
- It sits between the ctrl_t register file and the weight/input/softmax controllers, which consume step/tile/head.

Parameters:
- MaxOutstanding, 4, maximum issued-but-uncompleted tiles.
- H, ita_package::H, maximum heads supported (sizes head counter).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  single-cycle start request; accepted only in Idle.
- n_heads_i  in  n_heads_t  heads for this run (ctrl_t.n_heads).
- lin_tiles_i  in  tile_t  tiles per Q/K/V/OW step.
- attn_tiles_i  in  tile_t  tiles per QK/AV step.
- cmd_valid_o  out  1  tile command valid.
- cmd_ready_i  in  1  datapath accepts command.
- cmd_step_o  out  step_e  step of current command.
- cmd_tile_o  out  tile_t  tile index within step, 0-based.
- cmd_head_o  out  idx_width(H)  head index (0 during OW).
- cmd_last_o  out  1  command is last tile of its step.
- tile_done_i  in  1  one pulse per completed tile, in order.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle pulse at run completion.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset values: cmd_valid_o=0, cmd_step_o=Idle, cmd_tile_o=0, cmd_head_o=0, cmd_last_o=0, busy_o=0, done_o=0, err_o=0. All internal counters are cleared. Reset has priority over all other inputs, including mid-run; no done_o is produced for an aborted run.
- Config latch: n_heads_i, lin_tiles_i and attn_tiles_i are registered on the cycle start_i is accepted. Later changes have no effect until the next run.
- FSM states:
  - IDLE: busy_o=0. On start_i, latch config, set busy_o=1, go to SELECT.
  - SELECT: compute the next non-empty step in combinational order and go to ISSUE (one cycle); if no steps remain, go to DRAIN_END.
    - Order: for head h in 0..n_heads-1: Q,K,V (lin_tiles) then QK,AV (attn_tiles); then OW (lin_tiles).
    - A step with 0 tiles is skipped.
    - n_heads=0 skips the head loop entirely.
  - ISSUE: cmd_valid_o=1 while outstanding<MaxOutstanding.
    - Handshake fires when cmd_valid_o&cmd_ready_i. On fire: tile++, outstanding++.
    - cmd_last_o=1 when tile==count-1; a fire with cmd_last_o=1 goes to BARRIER.
    - Command fields stay stable while valid && !ready. The command is never withdrawn once cmd_valid_o is raised.
  - BARRIER: cmd_valid_o=0. Wait for outstanding==0, then go to SELECT.
  - DRAIN_END: wait for outstanding==0, pulse done_o for one cycle, go to IDLE with busy_o=0 and cmd_step_o=Idle.
- Outstanding counter: width idx_width(MaxOutstanding+1).
  - Handshake fire and tile_done_i in the same cycle: net change 0.
  - tile_done_i with outstanding==0 and no fire that cycle: counter unchanged, err_o set sticky (cleared only by rst_i).
- Latency: the first command is valid 2 cycles after the start_i cycle (latch, then SELECT). The next step's first command is valid 2 cycles after the final tile_done_i of the previous step.
- start_i while busy_o=1 is ignored and has no side effects.
- Tile counters are 32-bit and compare against the latched count, so they do not wrap within a legal run.

Decomposition:
- Add to ita_package:
  - typedef seq_state_e {SeqIdle, SeqSelect, SeqIssue, SeqBarrier, SeqDrainEnd};
  - localparam MaxOutstandingTiles=4;
  - typedef outstanding_t.
- Sub-module ita_step_order: purely combinational next-step function of (current step, head, latched config) returning (next step, next head, tile count, end flag). This keeps the FSM free of ordering logic and makes the order testable on its own.

Test Plan:
- n_heads=1, lin=2, attn=1, ready=1, done returned 3 cycles after each fire. Expected: command sequence Q0,Q1,K0,K1,V0,V1,QK0,AV0,OW0,OW1, all head 0, with cmd_last_o on Q1,K1,V1,QK0,AV0,OW1. Exactly one done_o pulse; busy_o falls the same cycle.
- n_heads=2, lin=1, attn=2. Expected: cmd_head_o=0 for the first 7 commands and 1 for the next 7, then OW0 with head 0. 15 commands total.
- Backpressure: cmd_ready_i=0 for 5 cycles mid-Q. Expected: cmd_valid_o stays high and step/tile/head stay stable. Separately, never return tile_done_i with lin=8. Expected: cmd_valid_o drops after 4 fires (MaxOutstanding).
- Zero counts: attn=0, lin=1, n_heads=1. Expected: sequence Q,K,V,OW. Then lin=0, attn=0. Expected: no commands and done_o 2 cycles after start.
- Protocol checks:
  - Spurious tile_done_i in IDLE sets err_o; err_o persists until rst_i.
  - Simultaneous fire and tile_done_i leaves outstanding unchanged.
  - start_i while busy is ignored.
- Assert rst_i mid-AV. Expected: next cycle all outputs are at reset values, no done_o, and a new start runs a full correct sequence.

Source files
------------

// File: rtl/ita_package.sv
`default_nettype none
// ============================================================================
// Module   : ita_package
// Purpose  : Shared types and constants for the ITA attention tile scheduler.
//            Holds the step and sequencer-state encodings, tile and head
//            count types, and the idx_width() helper used to size counters.
// Revision : 1.0 - initial release
// ============================================================================
package ita_package;

    // Counter width needed to index n items (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int H                   = 4;
    localparam int MaxOutstandingTiles = 4;

    // Wide enough to hold the value H itself, not only indices below it.
    typedef logic [idx_width(H+1)-1:0]                   n_heads_t;
    typedef logic [31:0]                                 tile_t;
    typedef logic [idx_width(MaxOutstandingTiles+1)-1:0] outstanding_t;

    typedef enum logic [2:0] {
        StepIdle = 3'd0,
        StepQ    = 3'd1,
        StepK    = 3'd2,
        StepV    = 3'd3,
        StepQK   = 3'd4,
        StepAV   = 3'd5,
        StepOW   = 3'd6
    } step_e;

    typedef enum logic [2:0] {
        SeqIdle     = 3'd0,
        SeqSelect   = 3'd1,
        SeqIssue    = 3'd2,
        SeqBarrier  = 3'd3,
        SeqDrainEnd = 3'd4
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/ita_step_order.sv
`default_nettype none
// ============================================================================
// Module   : ita_step_order
// Purpose  : Purely combinational successor function of the run order.
//            Given the step just completed (StepIdle before the first step)
//            and its head, returns the next non-empty step, its head, its tile
//            count, and an end flag when nothing remains.
//            Order per head: Q, K, V (lin tiles), QK, AV (attn tiles);
//            after all heads: OW (lin tiles).
// Ports    : cur_step_i/cur_head_i  position just finished
//            n_heads_i, lin_tiles_i, attn_tiles_i  latched run configuration
//            next_step_o/next_head_o/count_o  next step to issue
//            end_o  no step remains
// Revision : 1.0 - initial release
// ============================================================================
module ita_step_order
    import ita_package::*;
#(
    parameter int H = ita_package::H
) (
    input  step_e                   cur_step_i,
    input  logic [idx_width(H)-1:0] cur_head_i,
    input  n_heads_t                n_heads_i,
    input  tile_t                   lin_tiles_i,
    input  tile_t                   attn_tiles_i,
    output step_e                   next_step_o,
    output logic [idx_width(H)-1:0] next_head_o,
    output tile_t                   count_o,
    output logic                    end_o
);

    logic w_has_lin;
    logic w_has_attn;
    logic w_more_heads;
    logic w_enter_head;
    logic w_enter_ow;

    assign w_has_lin    = (lin_tiles_i != '0);
    assign w_has_attn   = (attn_tiles_i != '0);
    assign w_more_heads = ((32'(cur_head_i) + 32'd1) < 32'(n_heads_i));

    always_comb begin
        next_step_o  = StepIdle;
        next_head_o  = cur_head_i;
        count_o      = '0;
        end_o        = 1'b0;
        w_enter_head = 1'b0;
        w_enter_ow   = 1'b0;

        case (cur_step_i)
            StepIdle: begin
                next_head_o = '0;
                if (n_heads_i != '0) begin
                    w_enter_head = 1'b1;
                end else begin
                    w_enter_ow = 1'b1;
                end
            end
            StepQ:  next_step_o = StepK;
            StepK:  next_step_o = StepV;
            StepV: begin
                if (w_has_attn) begin
                    next_step_o = StepQK;
                end else if (w_more_heads) begin
                    next_head_o  = cur_head_i + 1'b1;
                    w_enter_head = 1'b1;
                end else begin
                    w_enter_ow = 1'b1;
                end
            end
            StepQK: next_step_o = StepAV;
            StepAV: begin
                if (w_more_heads) begin
                    next_head_o  = cur_head_i + 1'b1;
                    w_enter_head = 1'b1;
                end else begin
                    w_enter_ow = 1'b1;
                end
            end
            default: w_enter_ow = 1'b0;
        endcase

        // First non-empty step of a head. A head with both counts zero means
        // every head is empty, so fall straight through to the OW check.
        if (w_enter_head) begin
            if (w_has_lin) begin
                next_step_o = StepQ;
            end else if (w_has_attn) begin
                next_step_o = StepQK;
            end else begin
                w_enter_ow = 1'b1;
            end
        end

        if (w_enter_ow) begin
            next_head_o = '0;
            if (w_has_lin) begin
                next_step_o = StepOW;
            end else begin
                end_o = 1'b1;
            end
        end

        // After StepOW nothing remains.
        if (cur_step_i == StepOW) begin
            next_step_o = StepIdle;
            next_head_o = '0;
            end_o       = 1'b1;
        end

        case (next_step_o)
            StepQ, StepK, StepV, StepOW: count_o = lin_tiles_i;
            StepQK, StepAV:              count_o = attn_tiles_i;
            default:                     count_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ita_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ita_step_sequencer
// Purpose  : Tile scheduler for the ITA attention datapath. Latches the run
//            configuration on start, walks Q,K,V,QK,AV per head then OW,
//            issues one tile command per valid/ready handshake, holds a
//            barrier between steps and bounds issued-but-uncompleted tiles.
// Ports    : clk_i, rst_i (sync, active high)
//            start_i, n_heads_i, lin_tiles_i, attn_tiles_i  run request
//            cmd_valid_o/cmd_ready_i, cmd_step_o, cmd_tile_o, cmd_head_o,
//            cmd_last_o  tile command channel
//            tile_done_i  in-order tile completion pulses
//            busy_o, done_o (one-cycle), err_o (sticky)
// Revision : 1.0 - initial release
// ============================================================================
module ita_step_sequencer
    import ita_package::*;
#(
    parameter int MaxOutstanding = MaxOutstandingTiles,
    parameter int H              = ita_package::H
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  n_heads_t                n_heads_i,
    input  tile_t                   lin_tiles_i,
    input  tile_t                   attn_tiles_i,
    output logic                    cmd_valid_o,
    input  logic                    cmd_ready_i,
    output step_e                   cmd_step_o,
    output tile_t                   cmd_tile_o,
    output logic [idx_width(H)-1:0] cmd_head_o,
    output logic                    cmd_last_o,
    input  logic                    tile_done_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    localparam int OUT_W = idx_width(MaxOutstanding + 1);
    localparam int HEAD_W = idx_width(H);
    typedef logic [OUT_W-1:0] out_cnt_t;
    localparam out_cnt_t c_max_out = out_cnt_t'(MaxOutstanding);

    seq_state_e          r_state;
    seq_state_e          w_state_next;
    n_heads_t            r_n_heads;
    tile_t               r_lin;
    tile_t               r_attn;
    tile_t               r_tile;
    tile_t               r_count;
    step_e               r_step;
    logic [HEAD_W-1:0]   r_head;
    out_cnt_t            r_out;
    out_cnt_t            w_out_next;
    logic                r_err;

    step_e               w_ord_step;
    logic [HEAD_W-1:0]   w_ord_head;
    tile_t               w_ord_count;
    logic                w_ord_end;

    logic                w_valid;
    logic                w_fire;
    logic                w_last;
    logic                w_done_ok;
    logic                w_spurious;
    logic                w_done;
    n_heads_t            w_n_heads_clamped;

    ita_step_order #(.H(H)) u_order (
        .cur_step_i   (r_step),
        .cur_head_i   (r_head),
        .n_heads_i    (r_n_heads),
        .lin_tiles_i  (r_lin),
        .attn_tiles_i (r_attn),
        .next_step_o  (w_ord_step),
        .next_head_o  (w_ord_head),
        .count_o      (w_ord_count),
        .end_o        (w_ord_end)
    );

    // Heads beyond H cannot be indexed by the head counter.
    assign w_n_heads_clamped = (32'(n_heads_i) > H) ? n_heads_t'(H) : n_heads_i;

    assign w_valid    = (r_state == SeqIssue) && (r_out < c_max_out);
    assign w_fire     = w_valid && cmd_ready_i;
    assign w_last     = (r_tile == (r_count - 32'd1));
    // A completion landing in the same cycle as an issue is always legal,
    // even with nothing previously outstanding; it nets to zero.
    assign w_done_ok  = tile_done_i && ((r_out != '0) || w_fire);
    assign w_spurious = tile_done_i && (r_out == '0) && !w_fire;
    assign w_out_next = r_out + out_cnt_t'(w_fire) - out_cnt_t'(w_done_ok);
    assign w_done     = (r_state == SeqDrainEnd) && (r_out == '0) && !rst_i;

    assign cmd_valid_o = w_valid;
    assign cmd_step_o  = r_step;
    assign cmd_tile_o  = r_tile;
    assign cmd_head_o  = r_head;
    assign cmd_last_o  = (r_state == SeqIssue) && w_last;
    assign busy_o      = (r_state != SeqIdle) && !w_done;
    assign done_o      = w_done;
    assign err_o       = r_err;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SeqIdle:     if (start_i) w_state_next = SeqSelect;
            SeqSelect:   w_state_next = w_ord_end ? SeqDrainEnd : SeqIssue;
            SeqIssue:    if (w_fire && w_last) w_state_next = SeqBarrier;
            // Looking at the post-update count lets the final completion
            // release the barrier in the same cycle it arrives.
            SeqBarrier:  if (w_out_next == '0) w_state_next = SeqSelect;
            SeqDrainEnd: if (r_out == '0) w_state_next = SeqIdle;
            default:     w_state_next = SeqIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= SeqIdle;
            r_n_heads <= '0;
            r_lin     <= '0;
            r_attn    <= '0;
            r_tile    <= '0;
            r_count   <= '0;
            r_step    <= StepIdle;
            r_head    <= '0;
            r_out     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_out   <= w_out_next;
            if (w_spurious) begin
                r_err <= 1'b1;
            end
            case (r_state)
                SeqIdle: begin
                    if (start_i) begin
                        r_n_heads <= w_n_heads_clamped;
                        r_lin     <= lin_tiles_i;
                        r_attn    <= attn_tiles_i;
                        r_step    <= StepIdle;
                        r_head    <= '0;
                        r_tile    <= '0;
                    end
                end
                SeqSelect: begin
                    r_tile <= '0;
                    if (w_ord_end) begin
                        r_step <= StepIdle;
                        r_head <= '0;
                    end else begin
                        r_step  <= w_ord_step;
                        r_head  <= w_ord_head;
                        r_count <= w_ord_count;
                    end
                end
                SeqIssue: begin
                    if (w_fire) begin
                        r_tile <= r_tile + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ita_step_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ita_step_sequencer
// Purpose  : Directed self-checking bench for ita_step_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ita_step_sequencer;
    import ita_package::*;

    localparam int HW = idx_width(H);

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    n_heads_t        n_heads;
    tile_t           lin;
    tile_t           attn;
    logic            valid;
    logic            ready;
    step_e           step;
    tile_t           tile;
    logic [HW-1:0]   head;
    logic            last;
    logic            tile_done;
    logic            busy;
    logic            done;
    logic            err;

    logic            auto_done;
    logic            man_done;
    logic [3:0]      hist;

    int              n_cmp = 0;
    int              n_bad = 0;
    int              n_done_pulses = 0;

    step_e           q_step[$];
    int              q_tile[$];
    int              q_head[$];
    int              q_last[$];

    always #5 clk = ~clk;

    // Completions return three cycles after each handshake when enabled.
    assign tile_done = (auto_done & hist[2]) | man_done;

    ita_step_sequencer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .n_heads_i    (n_heads),
        .lin_tiles_i  (lin),
        .attn_tiles_i (attn),
        .cmd_valid_o  (valid),
        .cmd_ready_i  (ready),
        .cmd_step_o   (step),
        .cmd_tile_o   (tile),
        .cmd_head_o   (head),
        .cmd_last_o   (last),
        .tile_done_i  (tile_done),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err)
    );

    always @(posedge clk) begin
        if (rst) hist <= 4'b0;
        else     hist <= {hist[2:0], valid & ready};
        if (!rst && valid && ready) begin
            q_step.push_back(step);
            q_tile.push_back(int'(tile));
            q_head.push_back(int'(head));
            q_last.push_back(int'(last));
        end
        if (done) n_done_pulses <= n_done_pulses + 1;
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns at the negedge following the start-accepting edge.
    task automatic start_run(input int nh, input int nl, input int na);
        @(negedge clk);
        n_heads = n_heads_t'(nh);
        lin     = tile_t'(nl);
        attn    = tile_t'(na);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({valid, step, tile, head, last, busy, done, err} !==
            {1'b0, StepIdle, 32'd0, {HW{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_values: got v=%b s=%0d t=%0d h=%0d l=%b b=%b d=%b e=%b required all zero",
                     valid, step, tile, head, last, busy, done, err);
        end
    endtask

    task automatic test_basic();
        step_e es[10];
        int et[10], el[10];
        int b, d0;
        bit ok;
        es = '{StepQ, StepQ, StepK, StepK, StepV, StepV, StepQK, StepAV, StepOW, StepOW};
        et = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 1};
        el = '{0, 1, 0, 1, 0, 1, 1, 1, 0, 1};
        b = q_step.size(); d0 = n_done_pulses;
        auto_done = 1'b1; ready = 1'b1;
        start_run(1, 2, 1);
        n_heads = 3; lin = 7; attn = 9;  // must not affect the running job
        n_cmp++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_select_cycle: got valid=%b busy=%b required valid=0 busy=1", valid, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (valid !== 1'b1 || step !== StepQ || tile !== 0) begin
            n_bad++;
            $display("FAIL basic_first_cmd: got valid=%b step=%0d tile=%0d required 1/Q/0", valid, step, tile);
        end
        wait_done(300, ok);
        n_cmp++;
        if (!ok || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_done: got done_seen=%b busy=%b required 1/0", ok, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || (n_done_pulses - d0) !== 1) begin
            n_bad++;
            $display("FAIL basic_done_single: got done=%b pulses=%0d required 0/1", done, n_done_pulses - d0);
        end
        n_cmp++;
        if (q_step.size() - b !== 10) begin
            n_bad++;
            $display("FAIL basic_cmd_count: got %0d required 10", q_step.size() - b);
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_cmp++;
                if (q_step[b+i] !== es[i] || q_tile[b+i] !== et[i] || q_head[b+i] !== 0 || q_last[b+i] !== el[i]) begin
                    n_bad++;
                    $display("FAIL basic_cmd[%0d]: got s=%0d t=%0d h=%0d l=%0d required s=%0d t=%0d h=0 l=%0d",
                             i, q_step[b+i], q_tile[b+i], q_head[b+i], q_last[b+i], es[i], et[i], el[i]);
                end
            end
        end
    endtask

    task automatic test_two_heads();
        step_e es[15];
        int et[15], eh[15], el[15];
        int b;
        bit ok;
        es = '{StepQ, StepK, StepV, StepQK, StepQK, StepAV, StepAV,
               StepQ, StepK, StepV, StepQK, StepQK, StepAV, StepAV, StepOW};
        et = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0};
        eh = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
        el = '{1, 1, 1, 0, 1, 0, 1, 1, 1, 1, 0, 1, 0, 1, 1};
        b = q_step.size();
        start_run(2, 1, 2);
        wait_done(500, ok);
        n_cmp++;
        if (!ok || q_step.size() - b !== 15) begin
            n_bad++;
            $display("FAIL two_heads_count: got done_seen=%b cmds=%0d required 1/15", ok, q_step.size() - b);
        end else begin
            for (int i = 0; i < 15; i++) begin
                n_cmp++;
                if (q_step[b+i] !== es[i] || q_tile[b+i] !== et[i] || q_head[b+i] !== eh[i] || q_last[b+i] !== el[i]) begin
                    n_bad++;
                    $display("FAIL two_heads_cmd[%0d]: got s=%0d t=%0d h=%0d l=%0d required s=%0d t=%0d h=%0d l=%0d",
                             i, q_step[b+i], q_tile[b+i], q_head[b+i], q_last[b+i], es[i], et[i], eh[i], el[i]);
                end
            end
        end
    endtask

    task automatic test_zero_counts();
        step_e es[4];
        int b, d0;
        bit ok;
        es = '{StepQ, StepK, StepV, StepOW};
        b = q_step.size();
        start_run(1, 1, 0);
        wait_done(200, ok);
        n_cmp++;
        if (!ok || q_step.size() - b !== 4) begin
            n_bad++;
            $display("FAIL zero_attn_count: got done_seen=%b cmds=%0d required 1/4", ok, q_step.size() - b);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (q_step[b+i] !== es[i] || q_tile[b+i] !== 0 || q_last[b+i] !== 1) begin
                    n_bad++;
                    $display("FAIL zero_attn_cmd[%0d]: got s=%0d t=%0d l=%0d required s=%0d t=0 l=1",
                             i, q_step[b+i], q_tile[b+i], q_last[b+i], es[i]);
                end
            end
        end
        @(negedge clk);
        b = q_step.size(); d0 = n_done_pulses;
        start_run(1, 0, 0);
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL empty_done_early: got done=%b required 0", done);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin
            n_bad++;
            $display("FAIL empty_done_latency: got done=%b busy=%b valid=%b required 1/0/0", done, busy, valid);
        end
        @(negedge clk);
        n_cmp++;
        if (q_step.size() !== b || n_done_pulses - d0 !== 1) begin
            n_bad++;
            $display("FAIL empty_no_cmds: got cmds=%0d pulses=%0d required 0/1", q_step.size() - b, n_done_pulses - d0);
        end
    endtask

    task automatic test_backpressure();
        int b;
        bit ok;
        b = q_step.size();
        start_run(1, 4, 0);
        @(negedge clk);   // Q0 presented, fires next edge
        @(negedge clk);   // Q1 presented
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (valid !== 1'b1 || step !== StepQ || tile !== 1 || head !== 0) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got valid=%b step=%0d tile=%0d head=%0d required 1/Q/1/0",
                         i, valid, step, tile, head);
            end
        end
        ready = 1'b1;
        wait_done(400, ok);
        n_cmp++;
        if (!ok || q_step.size() - b !== 16) begin
            n_bad++;
            $display("FAIL stall_total: got done_seen=%b cmds=%0d required 1/16", ok, q_step.size() - b);
        end
    endtask

    task automatic test_limit_and_simul();
        int b;
        b = q_step.size();
        auto_done = 1'b0;
        start_run(1, 8, 0);
        repeat (8) @(negedge clk);
        n_cmp++;
        if (q_step.size() - b !== 4 || valid !== 1'b0) begin
            n_bad++;
            $display("FAIL limit_fires: got fires=%0d valid=%b required 4/0", q_step.size() - b, valid);
        end
        man_done = 1'b1;          // 4 -> 3
        @(negedge clk);
        n_cmp++;
        if (valid !== 1'b1) begin
            n_bad++;
            $display("FAIL limit_release: got valid=%b required 1", valid);
        end
        @(negedge clk);           // fire plus done in the same cycle: stays 3
        man_done = 1'b0;
        n_cmp++;
        if (valid !== 1'b1 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL simul_net_zero: got valid=%b err=%b required 1/0", valid, err);
        end
        @(negedge clk);           // plain fire: back to 4
        n_cmp++;
        if (valid !== 1'b0 || q_step.size() - b !== 6) begin
            n_bad++;
            $display("FAIL simul_refill: got valid=%b fires=%0d required 0/6", valid, q_step.size() - b);
        end
        do_reset();
        auto_done = 1'b1;
    endtask

    task automatic test_start_busy();
        step_e es[10];
        int b, d0;
        bit ok;
        es = '{StepQ, StepQ, StepK, StepK, StepV, StepV, StepQK, StepAV, StepOW, StepOW};
        b = q_step.size(); d0 = n_done_pulses;
        start_run(1, 2, 1);
        repeat (4) @(negedge clk);
        n_heads = 2; lin = 5; attn = 3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(300, ok);
        @(negedge clk);
        n_cmp++;
        if (!ok || q_step.size() - b !== 10 || n_done_pulses - d0 !== 1) begin
            n_bad++;
            $display("FAIL busy_start_count: got done_seen=%b cmds=%0d pulses=%0d required 1/10/1",
                     ok, q_step.size() - b, n_done_pulses - d0);
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_cmp++;
                if (q_step[b+i] !== es[i]) begin
                    n_bad++;
                    $display("FAIL busy_start_cmd[%0d]: got s=%0d required s=%0d", i, q_step[b+i], es[i]);
                end
            end
        end
    endtask

    task automatic test_err();
        @(negedge clk);
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_set: got err=%b required 1", err);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky: got err=%b required 1", err);
        end
        do_reset();
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear: got err=%b required 0", err);
        end
    endtask

    task automatic test_reset_mid_run();
        step_e es[6];
        int b, d0;
        bit found, ok;
        es = '{StepQ, StepK, StepV, StepQK, StepAV, StepOW};
        found = 1'b0;
        start_run(1, 1, 2);
        for (int i = 0; i < 200; i++) begin
            if (valid === 1'b1 && step === StepAV) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL midrun_reach_av: got found=0 required 1");
        end
        d0 = n_done_pulses;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({valid, step, tile, head, last, busy, done, err} !==
            {1'b0, StepIdle, 32'd0, {HW{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL midrun_reset_values: got v=%b s=%0d t=%0d h=%0d l=%b b=%b d=%b e=%b required all zero",
                     valid, step, tile, head, last, busy, done, err);
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (n_done_pulses !== d0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midrun_no_done: got pulses=%0d busy=%b required 0/0", n_done_pulses - d0, busy);
        end
        b = q_step.size();
        start_run(1, 1, 1);
        wait_done(300, ok);
        n_cmp++;
        if (!ok || q_step.size() - b !== 6) begin
            n_bad++;
            $display("FAIL midrun_restart_count: got done_seen=%b cmds=%0d required 1/6", ok, q_step.size() - b);
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (q_step[b+i] !== es[i] || q_last[b+i] !== 1) begin
                    n_bad++;
                    $display("FAIL midrun_restart_cmd[%0d]: got s=%0d l=%0d required s=%0d l=1",
                             i, q_step[b+i], q_last[b+i], es[i]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; n_heads = '0; lin = '0; attn = '0;
        ready = 1'b1; auto_done = 1'b1; man_done = 1'b0;
        test_reset();
        test_basic();
        test_two_heads();
        test_zero_counts();
        test_backpressure();
        test_limit_and_simul();
        test_start_busy();
        test_err();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
